// File: rtl/i2s_rx_if.sv
// I2S receiver bus bundle: the three pins coming from the external master
// and the recovered-sample outputs. The master modport is the side that
// drives the I2S pins and consumes the samples; the slave modport is the
// receiver itself.
interface i2s_rx_if #(
  parameter int AUDIO_DW = 8
);
  logic                sck_i;
  logic                ws_i;
  logic                sd_i;
  logic [AUDIO_DW-1:0] l_data_o;
  logic [AUDIO_DW-1:0] r_data_o;
  logic                l_valid_o;
  logic                r_valid_o;
  logic                short_err_o;

  modport master (
    output sck_i,
    output ws_i,
    output sd_i,
    input  l_data_o,
    input  r_data_o,
    input  l_valid_o,
    input  r_valid_o,
    input  short_err_o
  );

  modport slave (
    input  sck_i,
    input  ws_i,
    input  sd_i,
    output l_data_o,
    output r_data_o,
    output l_valid_o,
    output r_valid_o,
    output short_err_o
  );
endinterface

// File: rtl/i2s_rx.sv
// I2S receiver. SCK, WS and SD are oversampled in the clk_i domain through
// identical two-flop synchronizers, SCK rising edges are detected with one
// extra flop, and all protocol state advances only on detected rises.
// Words are captured MSB first with the standard one-bit delay after each
// WS edge; slots shorter than AUDIO_DW bits raise a one-cycle error pulse
// and are discarded, longer slots are truncated to their top AUDIO_DW bits.
module i2s_rx #(
  parameter int AUDIO_DW = 8
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  i2s_rx_if.slave  bus
);

  localparam int              CW     = $clog2(AUDIO_DW + 1);
  localparam logic [CW-1:0]   FULL_C = CW'(AUDIO_DW);
  localparam logic [CW-1:0]   ONE_C  = CW'(1);
  localparam logic [CW-1:0]   ZERO_C = CW'(0);

  // Capture is disabled until the first WS edge gives a slot boundary.
  typedef enum logic [0:0] {
    ST_WAIT_WS = 1'b0,
    ST_ACTIVE  = 1'b1
  } state_e;

  // Synchronizer chains, bit order {sck, ws, sd} so all pins share one path.
  logic [2:0]          meta_r;
  logic [2:0]          sync_r;
  logic                sck_q_r;

  logic                sck_s;
  logic                ws_s;
  logic                sd_s;
  logic                rise_s;

  state_e              state_r,     state_nxt;
  logic                ch_r,        ch_nxt;
  logic [CW-1:0]       cnt_r,       cnt_nxt;
  logic [AUDIO_DW-1:0] shreg_r,     shreg_nxt;
  logic                ws_d_r,      ws_d_nxt;
  logic [AUDIO_DW-1:0] l_data_r,    l_data_nxt;
  logic [AUDIO_DW-1:0] r_data_r,    r_data_nxt;
  logic                l_valid_r,   l_valid_nxt;
  logic                r_valid_r,   r_valid_nxt;
  logic                short_err_r, short_err_nxt;

  logic                active_s;
  logic [CW-1:0]       cnt_cap_s;
  logic [AUDIO_DW-1:0] word_s;

  // Two-flop synchronizers for all pins plus the delayed SCK for edge detect.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_r  <= 3'b000;
      sync_r  <= 3'b000;
      sck_q_r <= 1'b0;
    end else begin
      meta_r  <= {bus.sck_i, bus.ws_i, bus.sd_i};
      sync_r  <= meta_r;
      sck_q_r <= sync_r[2];
    end
  end

  assign sck_s  = sync_r[2];
  assign ws_s   = sync_r[1];
  assign sd_s   = sync_r[0];
  assign rise_s = sck_s & ~sck_q_r;

  // Slot tracking, capture, word completion and short-slot detection.
  always_comb begin
    state_nxt     = state_r;
    ch_nxt        = ch_r;
    cnt_nxt       = cnt_r;
    shreg_nxt     = shreg_r;
    ws_d_nxt      = ws_d_r;
    l_data_nxt    = l_data_r;
    r_data_nxt    = r_data_r;
    l_valid_nxt   = 1'b0;
    r_valid_nxt   = 1'b0;
    short_err_nxt = 1'b0;
    cnt_cap_s     = cnt_r;
    word_s        = {shreg_r[AUDIO_DW-2:0], sd_s};

    case (state_r)
      ST_WAIT_WS: active_s = 1'b0;
      ST_ACTIVE:  active_s = 1'b1;
      default:    active_s = 1'b0;
    endcase

    if (rise_s) begin
      // Capture while the slot still has room; cnt saturates at a full word.
      if (active_s && (cnt_r < FULL_C)) begin
        shreg_nxt = word_s;
        cnt_cap_s = cnt_r + ONE_C;
        if (cnt_cap_s == FULL_C) begin
          if (ch_r == 1'b0) begin
            l_data_nxt  = word_s;
            l_valid_nxt = 1'b1;
          end else begin
            r_data_nxt  = word_s;
            r_valid_nxt = 1'b1;
          end
        end else begin
          l_valid_nxt = 1'b0;
          r_valid_nxt = 1'b0;
        end
      end else begin
        cnt_cap_s = cnt_r;
      end
      cnt_nxt = cnt_cap_s;

      // A WS edge closes the slot; an incomplete word is dropped and flagged.
      // The LSB of a full-length slot arrives on this same rise, so the
      // completion check above already counted it.
      if (ws_s != ws_d_r) begin
        if (active_s && (cnt_cap_s < FULL_C)) begin
          short_err_nxt = 1'b1;
        end else begin
          short_err_nxt = 1'b0;
        end
        ch_nxt    = ws_s;
        cnt_nxt   = ZERO_C;
        state_nxt = ST_ACTIVE;
      end else begin
        state_nxt = state_r;
      end

      ws_d_nxt = ws_s;
    end else begin
      state_nxt = state_r;
    end
  end

  // Protocol state and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_WAIT_WS;
      ch_r        <= 1'b0;
      cnt_r       <= ZERO_C;
      shreg_r     <= {AUDIO_DW{1'b0}};
      ws_d_r      <= 1'b0;
      l_data_r    <= {AUDIO_DW{1'b0}};
      r_data_r    <= {AUDIO_DW{1'b0}};
      l_valid_r   <= 1'b0;
      r_valid_r   <= 1'b0;
      short_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      ch_r        <= ch_nxt;
      cnt_r       <= cnt_nxt;
      shreg_r     <= shreg_nxt;
      ws_d_r      <= ws_d_nxt;
      l_data_r    <= l_data_nxt;
      r_data_r    <= r_data_nxt;
      l_valid_r   <= l_valid_nxt;
      r_valid_r   <= r_valid_nxt;
      short_err_r <= short_err_nxt;
    end
  end

  assign bus.l_data_o    = l_data_r;
  assign bus.r_data_o    = r_data_r;
  assign bus.l_valid_o   = l_valid_r;
  assign bus.r_valid_o   = r_valid_r;
  assign bus.short_err_o = short_err_r;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed testbench for i2s_rx. Stimulus tasks drive I2S bits with SCK at
// clk/8 and push the expected pulses (kind + data) into a queue; a monitor
// on the falling clk edge pops one entry per observed pulse and compares.
module tb_i2s_rx;
  localparam int DW = 8;
  localparam logic [1:0] K_L   = 2'd0;
  localparam logic [1:0] K_R   = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;

  i2s_rx_if #(.AUDIO_DW(DW)) bus ();

  i2s_rx #(.AUDIO_DW(DW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    kind;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_pulse(input logic [1:0] k, input logic [DW-1:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // One SCK period: WS/SD change with the falling edge, 4 clk low, 4 clk high.
  task automatic send_bit(input logic w, input logic d);
    @(negedge clk);
    bus.sck_i = 1'b0;
    bus.ws_i  = w;
    bus.sd_i  = d;
    repeat (4) @(negedge clk);
    bus.sck_i = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Slot of len bits, MSB first; the LSB carries WS for the next slot.
  task automatic send_slot(input logic ch, input logic [15:0] data, input int len, input logic nxt);
    for (int i = 0; i < len; i++) begin
      send_bit((i == len - 1) ? nxt : ch, data[len - 1 - i]);
    end
  endtask

  // Monitor: every pulse cycle consumes one expected entry.
  always @(negedge clk) begin
    int            npulse;
    logic [1:0]    okind;
    logic [DW-1:0] odata;
    exp_t          e;
    npulse = int'(bus.l_valid_o) + int'(bus.r_valid_o) + int'(bus.short_err_o);
    if (npulse != 0) begin
      if (npulse > 1)          okind = 2'd3;
      else if (bus.l_valid_o)  okind = K_L;
      else if (bus.r_valid_o)  okind = K_R;
      else                     okind = K_ERR;
      odata = bus.r_valid_o ? bus.r_data_o : bus.l_data_o;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: got kind %0d data 0x%0h, expected no pulse", okind, odata);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {14'd0, okind}, {14'd0, e.kind});
        if (e.kind != K_ERR) begin
          check("pulse_data", {8'd0, odata}, {8'd0, e.data});
        end
      end
    end
  end

  initial begin
    logic [19:0] junk;
    junk = 20'hB6D3A;
    bus.sck_i = 1'b0;
    bus.ws_i  = 1'b0;
    bus.sd_i  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset held with the bus toggling: outputs stay at zero.
    for (int i = 0; i < 6; i++) begin
      send_bit(i[0], ~i[1]);
    end
    check("rst_l_data", {8'd0, bus.l_data_o}, 16'h0000);
    check("rst_r_data", {8'd0, bus.r_data_o}, 16'h0000);
    check("rst_pulses", {13'd0, bus.l_valid_o, bus.r_valid_o, bus.short_err_o}, 16'h0000);
    @(negedge clk);
    bus.sck_i = 1'b0;
    bus.ws_i  = 1'b0;
    repeat (4) @(negedge clk);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk);

    // Pre-sync SD activity with WS constant: nothing may be reported.
    for (int i = 0; i < 20; i++) begin
      send_bit(1'b0, junk[i]);
    end
    check("presync_l_data", {8'd0, bus.l_data_o}, 16'h0000);

    // First WS edge (to right), then right 0x5A, left 0x81, right 0x42.
    send_bit(1'b1, 1'b0);
    expect_pulse(K_R, 8'h5A);
    send_slot(1'b1, 16'h005A, 8, 1'b0);
    expect_pulse(K_L, 8'h81);
    send_slot(1'b0, 16'h0081, 8, 1'b1);
    expect_pulse(K_R, 8'h42);
    send_slot(1'b1, 16'h0042, 8, 1'b0);

    // Nominal stereo frames.
    for (int f = 0; f < 3; f++) begin
      expect_pulse(K_L, 8'hA5);
      send_slot(1'b0, 16'h00A5, 8, 1'b1);
      expect_pulse(K_R, 8'h3C);
      send_slot(1'b1, 16'h003C, 8, 1'b0);
    end

    // Long 16-bit slots: top byte kept, no error.
    expect_pulse(K_L, 8'hC3);
    send_slot(1'b0, 16'hC35A, 16, 1'b1);
    expect_pulse(K_R, 8'h0F);
    send_slot(1'b1, 16'h0FF0, 16, 1'b0);
    repeat (6) @(negedge clk);
    check("long_l_data", {8'd0, bus.l_data_o}, 16'h00C3);
    check("long_r_data", {8'd0, bus.r_data_o}, 16'h000F);

    // Short 5-bit left slot, then right 0x77.
    expect_pulse(K_ERR, 8'h00);
    send_slot(1'b0, 16'h0016, 5, 1'b1);
    expect_pulse(K_R, 8'h77);
    send_slot(1'b1, 16'h0077, 8, 1'b0);
    repeat (6) @(negedge clk);
    check("short_l_data_held", {8'd0, bus.l_data_o}, 16'h00C3);
    check("short_r_data", {8'd0, bus.r_data_o}, 16'h0077);

    // Mid-word reset after 4 bits of right word 0x9C.
    expect_pulse(K_L, 8'h11);
    send_slot(1'b0, 16'h0011, 8, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check("midrst_l_data", {8'd0, bus.l_data_o}, 16'h0000);
    check("midrst_r_data", {8'd0, bus.r_data_o}, 16'h0000);
    check("midrst_pulses", {13'd0, bus.l_valid_o, bus.r_valid_o, bus.short_err_o}, 16'h0000);
    check("midrst_pending", 16'(exp_q.size()), 16'h0000);
    bus.sck_i = 1'b0;
    repeat (4) @(negedge clk);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk);
    // WS=1 after reset looks like a fresh edge (ws_d cleared), so the
    // remaining 3 bits form a short right slot.
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    expect_pulse(K_ERR, 8'h00);
    send_bit(1'b0, 1'b0);
    expect_pulse(K_L, 8'h66);
    send_slot(1'b0, 16'h0066, 8, 1'b1);
    repeat (12) @(negedge clk);
    check("post_rst_l_data", {8'd0, bus.l_data_o}, 16'h0066);
    check("post_rst_r_data", {8'd0, bus.r_data_o}, 16'h0000);
    check("missing_pulses", 16'(exp_q.size()), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/i2s_rx.md
# i2s_rx

I2S receiver: oversamples an external I2S bus (SCK, WS, SD) in the system clock domain and recovers MSB-first left/right samples of `AUDIO_DW` bits. It is the receive counterpart of the existing `i2s_tx` and sits next to it in the top level. Uses:
- loopback checking of the transmitter (KS string / PRBS audio);
- capturing an external ADC stream whose last words are exposed through status registers.

The block drives no bus pins; SCK and WS come from the external master.

## Interface

Parameters:
- `AUDIO_DW`, default 8: captured word width, in bits.

Ports:
- `clk_i`  input  1: system clock. The only clock; SCK is treated as data.
- `rst_ni`  input  1: asynchronous, active-low reset.
- `sck_i`  input  1: I2S bit clock from the pin, asynchronous to `clk_i`.
- `ws_i`  input  1: word select from the pin. 0 = left, 1 = right.
- `sd_i`  input  1: serial data from the pin.
- `l_data_o`  output  AUDIO_DW: last complete left word.
- `r_data_o`  output  AUDIO_DW: last complete right word.
- `l_valid_o`  output  1: one-`clk_i` pulse when `l_data_o` updates.
- `r_valid_o`  output  1: one-`clk_i` pulse when `r_data_o` updates.
- `short_err_o`  output  1: one-`clk_i` pulse when a slot ended before `AUDIO_DW` bits were received.

## Operation

Input synchronisation and edge detection:
- `sck_i`, `ws_i` and `sd_i` each pass through an identical 2-flop synchronizer, so all three keep the same alignment.
- A third flop on synchronized SCK forms `rise = sck_s & ~sck_q`.
- All protocol state updates only on `clk_i` edges where `rise` = 1. Nothing in this block samples on SCK falling edges.

Protocol state:
- `ws_d`: WS value captured at the previous SCK rise.
- `active`: set once the first WS edge has been seen.
- `ch`: channel of the current slot.
- `cnt`: bits captured in the current slot, 0..AUDIO_DW.
- `shreg`: AUDIO_DW-bit shift register.

On each rise, in this order:
1. **Capture.** If `active` and `cnt < AUDIO_DW`: `shreg <= {shreg[AUDIO_DW-2:0], sd_s}`, `cnt <= cnt+1`.
2. **Word complete.** If this capture brings `cnt` to AUDIO_DW:
   - `ch`=0: load `{shreg[AUDIO_DW-2:0], sd_s}` into `l_data_o` and pulse `l_valid_o`.
   - `ch`=1: load it into `r_data_o` and pulse `r_valid_o`.
3. **WS edge.** If `ws_s != ws_d`:
   - If `active` and the count after step 1 is still below AUDIO_DW: pulse `short_err_o` and discard the partial word. No valid pulse.
   - Then `ch <= ws_s`, `cnt <= 0`, `active <= 1`.
4. `ws_d <= ws_s`.

Consequences:
- The MSB is the bit at the first rise after a WS edge. This gives standard I2S one-bit delay.
- When slot length equals AUDIO_DW, the LSB is the bit sampled on the rise that carries the next WS edge. That word completes normally, with no error.
- Slots longer than AUDIO_DW: the word is MSB-aligned; extra LSBs are ignored and `cnt` saturates at AUDIO_DW.
- Before the first WS edge after reset, SD is ignored and no valid or error pulses occur.
- Reset, including mid-word: all flops clear, and outputs return to their reset values within the reset assertion. Capture resumes only after a fresh WS edge.

## Timing

Reset values: `l_data_o` = 0, `r_data_o` = 0, all pulses 0, `active` = 0, `cnt` = 0, `ws_d` = 0, synchronizers 0.

Bus requirements at the pins:
- SCK high and low phases: each ≥ 2 `clk_i` periods.
- WS and SD: stable ≥ 1 `clk_i` period before and after each SCK rise.

Latency and output behaviour:
- `rise` asserts 2–3 `clk_i` edges after the pin rising edge, depending on sampling phase.
- Output data and valid update on the `clk_i` edge at which `rise` = 1.
- Each valid or error pulse is exactly 1 cycle wide. At most one of the three pulses is high on any cycle.
- `l_data_o` and `r_data_o` hold their value between updates.

## Test plan

- **Reset:** hold `rst_ni`=0 with the bus toggling → all outputs 0, no pulses. Release with WS constant → still no pulses.
- **Nominal stereo frame:** AUDIO_DW=8, 8-bit slots, SCK = clk/8. Left 0xA5, right 0x3C, repeated for 3 frames → `l_valid_o` carrying 0xA5 and `r_valid_o` carrying 0x3C once per frame, `short_err_o` never asserted.
- **Pre-sync data:** 20 SCK cycles of SD activity with WS held at 0, then a WS edge and a left word 0x81 → no pulse before the WS edge, then exactly one `r_valid_o` or `l_valid_o` pulse per following complete slot, first left word 0x81.
- **Long slot:** 16-bit slots with left 0xC35A and right 0x0FF0 → `l_data_o` = 0xC3, `r_data_o` = 0x0F, no error.
- **Short slot:** one 5-bit left slot, followed by a normal right slot 0x77 → one `short_err_o` pulse at the WS edge, no `l_valid_o`, `l_data_o` keeps its old value, `r_data_o` = 0x77.
- **Mid-word reset:** assert `rst_ni` after 4 bits of a right word → outputs are 0 immediately. After release, the first valid pulse occurs only after a new WS edge plus a complete slot.
